// File: rtl/param_fifo_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo_buffer_if
//  Description : Bus bundle between a producer/consumer and param_fifo_buffer.
//                Carries the control strobes, write data, read data, occupancy
//                count and all status/error flags.
//                  master : drives EN, CLR, CLR_ERR, WR, RD, dataIn;
//                           observes dataOut, count and the flags.
//                  slave  : the FIFO side of the same signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_fifo_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              EN;
    logic              CLR;
    logic              CLR_ERR;
    logic              WR;
    logic              RD;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic [CNT_W-1:0]  count;
    logic              EMPTY;
    logic              FULL;
    logic              ALMOST_EMPTY;
    logic              ALMOST_FULL;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output EN, CLR, CLR_ERR, WR, RD, dataIn,
        input  dataOut, count, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  EN, CLR, CLR_ERR, WR, RD, dataIn,
        output dataOut, count, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               OVERFLOW, UNDERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/param_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : param_fifo_buffer
//  Description : Parametrised single-clock FIFO with occupancy count,
//                almost-full / almost-empty watermarks, sticky overflow and
//                underflow flags and a synchronous flush.
//                Build option FIFO_FWFT_EN selects first-word-fall-through
//                reads; when undefined, reads are registered (1-cycle latency).
//  Ports       : Clk   - system clock, rising edge
//                Rst_n - asynchronous active-low reset
//                bus   - param_fifo_buffer_if.slave (controls, data, status)
//  Parameters  : DATA_W (word width), DEPTH (power of 2, >= 2),
//                AF_THRESH (1..DEPTH), AE_THRESH (0..DEPTH-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module param_fifo_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  wire logic          Clk,
    input  wire logic          Rst_n,
    param_fifo_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic w_full;
    logic w_empty;
    logic w_clr_acc;
    logic w_wr_acc;
    logic w_rd_acc;

    // Flags decode straight from the count register so they move on the
    // same edge as count.
    assign w_full  = (count_q == CW'(DEPTH));
    assign w_empty = (count_q == '0);

    // Flush wins over any data movement in the same cycle.
    assign w_clr_acc = bus.EN & bus.CLR;
    assign w_wr_acc  = bus.EN & ~bus.CLR & bus.WR & ~w_full;
    assign w_rd_acc  = bus.EN & ~bus.CLR & bus.RD & ~w_empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_clr_acc) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of 2, so the pointers wrap naturally.
            if (w_wr_acc) wptr_d = wptr_q + AW'(1);
            if (w_rd_acc) rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(w_wr_acc) - CW'(w_rd_acc);
        end
    end

    // Error flags ignore the flush; a new error in the same cycle as
    // CLR_ERR takes priority over the clear.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.EN) begin
            if (bus.CLR_ERR) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (bus.WR && w_full)  ovf_d = 1'b1;
            if (bus.RD && w_empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge Clk) begin
        if (w_wr_acc) mem[wptr_q] <= bus.dataIn;
    end

`ifdef FIFO_FWFT_EN
    // Head word is always visible; RD only acknowledges it.
    assign bus.dataOut = w_empty ? '0 : mem[rptr_q];
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (w_clr_acc)     dout_d = '0;
        else if (w_rd_acc) dout_d = mem[rptr_q];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign bus.dataOut = dout_q;
`endif

    assign bus.count        = count_q;
    assign bus.EMPTY        = w_empty;
    assign bus.FULL         = w_full;
    assign bus.ALMOST_EMPTY = (count_q <= CW'(AE_THRESH));
    assign bus.ALMOST_FULL  = (count_q >= CW'(AF_THRESH));
    assign bus.OVERFLOW     = ovf_q;
    assign bus.UNDERFLOW    = udf_q;
endmodule
`default_nettype wire

// File: tb/tb_param_fifo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_fifo_buffer
//  Description : Self-checking bench for param_fifo_buffer. A queue-based
//                model of the FIFO is compared with every DUT output on each
//                falling clock edge; directed steps add literal expectations.
//                Honours FIFO_FWFT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fifo_buffer;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;
    localparam int AE_THRESH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    param_fifo_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    param_fifo_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_THRESH(AF_THRESH),
        .AE_THRESH(AE_THRESH)
    ) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_ovf  = 1'b0;
    bit                m_udf  = 1'b0;
    bit                m_full, m_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (bus.EN) begin
            m_full  = (mq.size() == DEPTH);
            m_empty = (mq.size() == 0);
            if (bus.CLR_ERR) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (bus.WR && m_full)  m_ovf = 1'b1;
            if (bus.RD && m_empty) m_udf = 1'b1;
            if (bus.CLR) begin
                mq.delete();
                m_dout = '0;
            end else begin
                if (bus.RD && !m_empty) m_dout = mq.pop_front();
                if (bus.WR && !m_full)  mq.push_back(bus.dataIn);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (mq.size() == 0) ? '0 : mq[0];
`else
        return m_dout;
`endif
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_count",  bus.count,        mq.size());
        chk("m_empty",  bus.EMPTY,        mq.size() == 0);
        chk("m_full",   bus.FULL,         mq.size() == DEPTH);
        chk("m_aempty", bus.ALMOST_EMPTY, mq.size() <= AE_THRESH);
        chk("m_afull",  bus.ALMOST_FULL,  mq.size() >= AF_THRESH);
        chk("m_ovf",    bus.OVERFLOW,     m_ovf);
        chk("m_udf",    bus.UNDERFLOW,    m_udf);
        chk("m_dout",   bus.dataOut,      exp_dout());
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit en, input bit clr, input bit cerr,
                         input bit wr, input bit rd, input logic [DATA_W-1:0] d);
        @(negedge clk);
        #1;
        bus.EN      = en;
        bus.CLR     = clr;
        bus.CLR_ERR = cerr;
        bus.WR      = wr;
        bus.RD      = rd;
        bus.dataIn  = d;
    endtask

    task automatic op_wr(input logic [DATA_W-1:0] d); drive(1, 0, 0, 1, 0, d); endtask
    task automatic op_rd();   drive(1, 0, 0, 0, 1, '0); endtask
    task automatic op_idle(); drive(1, 0, 0, 0, 0, '0); endtask

    int ph;
    bit r_wr, r_rd;

    initial begin
        bus.EN = 0; bus.CLR = 0; bus.CLR_ERR = 0;
        bus.WR = 0; bus.RD = 0; bus.dataIn = '0;
        repeat (3) @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.EMPTY, 1);
        chk("rst_aempty", bus.ALMOST_EMPTY, 1);
        #1 rst_n = 1'b1;

        // Five writes then five back-to-back reads.
        for (int i = 0; i < 5; i++) op_wr(DATA_W'(i));
        for (int i = 0; i < 5; i++) begin
            op_rd();
`ifdef FIFO_FWFT_EN
            chk("t1_dout", bus.dataOut, i);
`else
            if (i > 0) chk("t1_dout", bus.dataOut, i - 1);
`endif
            if (i == 0) chk("t1_count5", bus.count, 5);
        end
        op_idle();
`ifdef FIFO_FWFT_EN
        chk("t1_dout_end", bus.dataOut, 0);
`else
        chk("t1_dout_end", bus.dataOut, 4);
`endif
        chk("t1_count0", bus.count, 0);
        chk("t1_empty", bus.EMPTY, 1);
        chk("t1_udf", bus.UNDERFLOW, 0);

        // Fill to full, overflow, clear the error.
        for (int i = 0; i < 9; i++) begin
            op_wr(DATA_W'(32'h10 + i));
            if (i == 6) begin
                chk("t2_count6", bus.count, 6);
                chk("t2_af6", bus.ALMOST_FULL, 1);
                chk("t2_full6", bus.FULL, 0);
            end
            if (i == 8) begin
                chk("t2_count8", bus.count, 8);
                chk("t2_full8", bus.FULL, 1);
                chk("t2_ovf_pre", bus.OVERFLOW, 0);
            end
        end
        op_idle();
        chk("t2_count_ovf", bus.count, 8);
        chk("t2_ovf", bus.OVERFLOW, 1);
        drive(1, 0, 1, 0, 0, '0);
        op_idle();
        chk("t2_ovf_clr", bus.OVERFLOW, 0);
`ifdef FIFO_FWFT_EN
        chk("t2_head", bus.dataOut, 32'h10);
`endif
        op_rd();
        op_idle();
`ifndef FIFO_FWFT_EN
        chk("t2_first", bus.dataOut, 32'h10);
`endif
        chk("t2_count7", bus.count, 7);
        for (int i = 0; i < 7; i++) op_rd();
        op_idle();
        chk("t2_drained", bus.count, 0);

        // Underflow on an empty FIFO, then RD+WR on empty.
        op_rd();
        op_idle();
        chk("t3_udf", bus.UNDERFLOW, 1);
        chk("t3_count", bus.count, 0);
`ifdef FIFO_FWFT_EN
        chk("t3_dout", bus.dataOut, 0);
`else
        chk("t3_dout", bus.dataOut, 32'h17);
`endif
        drive(1, 0, 1, 0, 0, '0);
        drive(1, 0, 0, 1, 1, 32'h55);
        op_idle();
        chk("t3_rdwr_count", bus.count, 1);
        chk("t3_rdwr_udf", bus.UNDERFLOW, 1);

        // Flush with a concurrent write; flags untouched.
        for (int i = 0; i < 4; i++) op_wr(DATA_W'(32'h60 + i));
        op_idle();
        chk("t4_count5", bus.count, 5);
        drive(1, 1, 0, 1, 0, 32'h99);
        op_idle();
        chk("t4_clr_count", bus.count, 0);
        chk("t4_clr_empty", bus.EMPTY, 1);
        chk("t4_clr_dout", bus.dataOut, 0);
        chk("t4_clr_udf", bus.UNDERFLOW, 1);

        // Asynchronous reset between edges.
        op_wr(32'h70);
        op_wr(32'h71);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.WR = 0;
        #1;
        chk("t4_ar_count", bus.count, 0);
        chk("t4_ar_empty", bus.EMPTY, 1);
        chk("t4_ar_dout", bus.dataOut, 0);
        chk("t4_ar_udf", bus.UNDERFLOW, 0);
        chk("t4_ar_af", bus.ALMOST_FULL, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Concurrent RD+WR at count 3, then wrap-around traffic.
        for (int i = 0; i < 3; i++) op_wr(DATA_W'(32'h100 + i));
        for (int k = 0; k < 20; k++) drive(1, 0, 0, 1, 1, DATA_W'(32'h200 + k));
        op_idle();
        chk("t5_count3", bus.count, 3);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) op_wr(DATA_W'(32'h300 + b * 5 + i));
            for (int i = 0; i < 5; i++) op_rd();
        end
        for (int i = 0; i < 3; i++) op_rd();
        op_idle();
        chk("t5_empty", bus.EMPTY, 1);

        // Single word: visible without RD in FWFT mode.
        op_wr(32'hA5);
        op_idle();
`ifdef FIFO_FWFT_EN
        chk("t6_fwft", bus.dataOut, 32'hA5);
`endif
        op_rd();
        op_idle();
        chk("t6_empty", bus.EMPTY, 1);
`ifdef FIFO_FWFT_EN
        chk("t6_dout", bus.dataOut, 0);
`else
        chk("t6_dout", bus.dataOut, 32'hA5);
`endif

        // Randomised traffic with fill/drain/balanced phases.
        for (int c = 0; c < 3000; c++) begin
            ph   = (c / 150) % 3;
            r_wr = (ph == 0) ? ($urandom_range(0, 9) < 8) :
                   (ph == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 1) == 1);
            r_rd = (ph == 0) ? ($urandom_range(0, 9) < 3) :
                   (ph == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0, r_wr, r_rd, $urandom);
        end
        op_idle();
        op_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_fifo_buffer.md
Name: param_fifo_buffer

Overview:
- Parametrised synchronous FIFO; next generation of the 32-bit FIFObuffer.
- Generic width and depth, occupancy count, almost-full and almost-empty watermarks, sticky overflow/underflow error flags, synchronous flush.
- Optional first-word-fall-through read mode.
- Sits between producer and consumer blocks in one clock domain.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- AF_THRESH, 6, ALMOST_FULL asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, ALMOST_EMPTY asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- EN  in  1  global enable; when 0, no read, write, flush, error set or error clear takes effect.
- CLR  in  1  synchronous flush, qualified by EN.
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW, qualified by EN.
- WR  in  1  write request.
- RD  in  1  read request.
- dataIn  in  DATA_W  write data.
- dataOut  out  DATA_W  read data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- EMPTY  out  1  count == 0.
- FULL  out  1  count == DEPTH.
- ALMOST_EMPTY  out  1  count <= AE_THRESH.
- ALMOST_FULL  out  1  count >= AF_THRESH.
- OVERFLOW  out  1  sticky: a write was attempted while FULL.
- UNDERFLOW  out  1  sticky: a read was attempted while EMPTY.

Behaviour:
- Reset (Rst_n=0, asynchronous): write/read pointers=0, count=0, dataOut=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. Memory contents are not reset.
- Reset asserted mid-operation: the state above applies immediately; all stored data is discarded.
- wr_acc = EN & WR & !FULL; rd_acc = EN & RD & !EMPTY. Rejected requests do not change pointers, count or memory.
- On wr_acc: mem[wptr] <= dataIn; wptr advances and wraps from DEPTH-1 to 0.
- On rd_acc (standard mode): dataOut <= mem[rptr] on the same edge, so data is valid 1 cycle after the RD edge. rptr advances and wraps. dataOut holds its value when no read is accepted.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- Simultaneous RD and WR while FULL: the read is accepted and the write is rejected; count becomes DEPTH-1 and OVERFLOW is set.
- Simultaneous RD and WR while EMPTY: the write is accepted and the read is rejected; count becomes 1 and UNDERFLOW is set.
- Status flags are decoded combinationally from the count register, so they change on the same edge as count with no extra lag.
- OVERFLOW is set on EN & WR & FULL; UNDERFLOW is set on EN & RD & EMPTY. Both stay set until a reset or CLR_ERR.
- CLR_ERR and a new error event in the same cycle: the set wins.
- CLR (with EN): pointers=0, count=0, dataOut=0. It overrides any read/write in the same cycle. Error flags are unaffected.
- Back-to-back full-rate writes and reads are supported, with no bubbles.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - dataOut = mem[rptr] combinationally whenever !EMPTY; dataOut=0 when EMPTY.
  - RD acts as a pop/acknowledge of the word currently shown.
  - The first written word appears on dataOut in the cycle after the write edge.
  - Count, flag and error rules are unchanged.
- Not defined: standard registered read with 1-cycle latency, as described under Behaviour.

Test Plan:
- Reset, then EN=1 and write 0x0..0x4 on 5 consecutive cycles, then RD for 5 cycles -> dataOut reads 0x0,0x1,0x2,0x3,0x4, each 1 cycle after its RD edge. count goes 5→0, EMPTY=1 at the end, UNDERFLOW=0.
- Write 8 words (DEPTH=8) -> count=6 gives ALMOST_FULL=1; count=8 gives FULL=1. A 9th write leaves count=8, sets OVERFLOW=1, and memory is unchanged (next read returns the 1st word). A CLR_ERR pulse clears OVERFLOW.
- At count=3, RD and WR held together for 20 cycles -> count stays 3 and data order is preserved. Then write/read 20 more words to exercise pointer wrap; every word returns in order.
- RD on an empty FIFO -> UNDERFLOW=1, dataOut unchanged, count=0. RD and WR together on an empty FIFO -> count=1, UNDERFLOW=1.
- With count=5, assert CLR together with WR -> count=0, EMPTY=1, dataOut=0, and the write is dropped. Then assert Rst_n=0 mid-stream between clock edges -> outputs take reset values immediately.
- With FIFO_FWFT_EN defined: write 0xA5 -> dataOut=0xA5 in the next cycle with no RD. RD pops it -> EMPTY=1 and dataOut=0.
